writeback_sel_pipe: RTL
=======================

# writeback_sel_pipe

Parametrised, registered write-back source selector for the processor datapath. Picks one of NSRC equal-width candidate values (HI/LO, ALU result, RS value, memory data, input port, immediate, PC, context PC, …) by a select code and buffers the result with its destination register and write enable. The result leaves through a valid/ready handshake backed by a 2-entry skid buffer, so the register-file write port can stall without a combinational ready path. Also exports counters and flags used by the OS-lab context-switch logic.

## Interface
- WIDTH, 32, data width of every source and of the output
- NSRC, 8, number of candidate sources (2..16)
- SELW, 3, select width; must satisfy NSRC ≤ 2^SELW
- ADDRW, 5, destination register address width
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- in_valid  in  1  upstream offers a write-back request
- in_ready  out  1  block can accept a request this cycle
- in_sel  in  SELW  source select; source k = in_src[k*WIDTH +: WIDTH]
- in_src  in  NSRC*WIDTH  flattened candidate values, source 0 in LSBs
- in_rd  in  ADDRW  destination register
- in_we  in  1  request writes the register file
- out_valid  out  1  output holds a request
- out_ready  in  1  register file consumes output this cycle
- out_data  out  WIDTH  selected value
- out_rd  out  ADDRW  destination register
- out_we  out  1  effective write enable
- sel_err  out  1  sticky: an out-of-range select was accepted
- wb_count  out  16  number of committed writes (out_we=1), wraps

## Operation
- Accept: in_valid && in_ready. Captured word = {data, rd, we} where data = in_src slice in_sel if in_sel < NSRC, else 0.
- Qualification at capture: we_eff = in_we && (in_rd != 0) && (in_sel < NSRC). Register 0 is never written.
- in_sel ≥ NSRC on accept: data 0, we_eff 0, sel_err set next edge; stays 1 until reset. Request still passes through (out_valid asserted) so upstream sequencing is preserved.
- Storage: main register M (drives outputs) and skid register S. States by occupancy: EMPTY (M empty), ONE (M full, S empty), TWO (both full).
- EMPTY: accept → ONE (word into M).
- ONE: commit only → EMPTY; accept only → TWO (word into S); commit+accept → ONE (new word into M).
- TWO: in_ready=0, no accept; commit → ONE (S moves to M).
- Commit: out_valid && out_ready. On commit with out_we=1, wb_count increments (16-bit wrap 0xFFFF→0x0000).
- Order strictly FIFO; no reordering, no dropped or duplicated requests.

## Timing
- Reset values: out_valid 0, in_ready 0 during the reset cycle then 1, out_data 0, out_rd 0, out_we 0, sel_err 0, wb_count 0; state EMPTY. Reset mid-transfer discards M and S contents.
- in_ready is a register output: 1 in EMPTY/ONE, 0 in TWO; no combinational path from out_ready or in_valid.
- Latency: accepted at edge t → visible on outputs after edge t (out_valid=1 in cycle t+1).
- Throughput: 1 request/cycle with out_ready held 1.
- Outputs stable while out_valid=1 and out_ready=0.
- out_ready drop: at most one further accept (into S); in_ready low the following cycle.
- out_ready rise in TWO: S reaches outputs one cycle after M commits; in_ready high again that cycle.
- Simultaneous reset and handshake: reset wins; nothing committed or counted.

## Test plan
- Sweep sel 0..7 with in_src[k]=0x1000_0000+k, rd=3, we=1, out_ready=1 → one cycle later out_data=0x1000_000k, out_rd=3, out_we=1; wb_count=8 after last commit.
- NSRC=6 build, accept sel=7 with we=1, rd=4 → out_data 0, out_we 0, out_valid 1, sel_err 1 and held until reset.
- rd=0, we=1, sel=1 (0xDEADBEEF) → out_data 0xDEADBEEF, out_we 0, wb_count unchanged.
- Stream A,B,C,D back-to-back, out_ready low for 3 cycles after A appears → A held, B in skid, in_ready 0, C waits; on release outputs A,B,C,D in order, no loss.
- wb_count preset by 65535 writes, one more write → wb_count 0x0000.
- Assert reset while in TWO → next cycle out_valid 0, wb_count 0, in_ready 1; queued words never appear.

Source files
------------

// File: rtl/writeback_sel_pipe.sv
// Registered write-back source selector: picks one of NSRC candidates, qualifies the
// write enable, and hands the result out through a 2-entry skid buffer (M drives outputs, S catches).
module writeback_sel_pipe #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 8,
    parameter int SELW  = 3,
    parameter int ADDRW = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       in_sel,
    input  logic [NSRC*WIDTH-1:0] in_src,
    input  logic [ADDRW-1:0]      in_rd,
    input  logic                  in_we,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [ADDRW-1:0]      out_rd,
    output logic                  out_we,
    output logic                  sel_err,
    output logic [15:0]           wb_count,
    output logic [1:0]            dbg_state_o
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready
    // (accept) and a result on an edge where out_valid && out_ready (commit);
    // a valid side holds its payload steady until the transfer happens.

    localparam int WW = WIDTH + ADDRW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   m_q, m_d;
    logic [WW-1:0]   s_q, s_d;
    logic            in_ready_q, in_ready_d;
    logic            sel_err_q, sel_err_d;
    logic [15:0]     wb_count_q, wb_count_d;

    logic            sel_ok;
    logic [WIDTH-1:0] cap_data;
    logic            cap_we;
    logic [WW-1:0]   cap_word;
    logic            accept;
    logic            commit;

    // Out-of-range selects match no source, leaving data 0 and sel_ok low.
    always_comb begin
        sel_ok   = 1'b0;
        cap_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (in_sel == SELW'(k)) begin
                sel_ok   = 1'b1;
                cap_data = in_src[k*WIDTH +: WIDTH];
            end
        end
        cap_we   = in_we && (in_rd != '0) && sel_ok;
        cap_word = {cap_data, in_rd, cap_we};
    end

    // Reset gates in_ready low while it is asserted so nothing is accepted then.
    assign in_ready  = in_ready_q && !reset;
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign commit    = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    m_d     = cap_word;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && commit) begin
                    m_d = cap_word;
                end else if (accept) begin
                    s_d     = cap_word;
                    state_d = ST_TWO;
                end else if (commit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (commit) begin
                    m_d     = s_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        in_ready_d = (state_d != ST_TWO);
        sel_err_d  = sel_err_q || (accept && !sel_ok);
        wb_count_d = wb_count_q;
        if (commit && m_q[0]) begin
            wb_count_d = wb_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            m_q        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b1;
            sel_err_q  <= 1'b0;
            wb_count_q <= '0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            s_q        <= s_d;
            in_ready_q <= in_ready_d;
            sel_err_q  <= sel_err_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign out_data    = m_q[WW-1 -: WIDTH];
    assign out_rd      = m_q[ADDRW:1];
    assign out_we      = m_q[0];
    assign sel_err     = sel_err_q;
    assign wb_count    = wb_count_q;
    assign dbg_state_o = state_q;

endmodule
